alarm_sequencer: RTL

Alarm control FSM for the digital alarm clock. It watches the running time and the stored alarm time, both in BCD from the counter/adjust datapath, and raises the ring when they match. It also sequences the ring timeout, snooze and stop, and drives the buzzer and status LEDs. It sits beside the mode FSM and takes the debounced button pulses and the 1 Hz tick from the existing divider.

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/sec_timer.sv | 37 +++
 rtl/alarm_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock control path.
// BCD time packing is {h_tens, h_units, m_tens, m_units}, most significant digit first.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } alarm_state_e;

   typedef struct packed {
      logic [3:0] h_tens;
      logic [3:0] h_units;
      logic [3:0] m_tens;
      logic [3:0] m_units;
   } bcd_time_t;

   localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/sec_timer.sv
// Loadable seconds down-counter; load wins over tick, saturates at zero, no backpressure.
// expire is combinational: high in the cycle whose tick takes the count from 1 to 0.
module sec_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Kept independent of load so the FSM can use it without a combinational loop.
   assign expire = tick && (cnt_q == W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop sequencer; outputs registered, 1-cycle latency from match or button pulse, no backpressure.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_MINS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic [15:0] time_bcd,
   input  logic [15:0] alarm_bcd,
   input  logic        arm,
   input  logic        adjusting,
   input  logic        snooze,
   input  logic        stop,
   output logic        ringing,
   output logic        buzzer,
   output logic        armed_led,
   output logic        snoozed
);

`ifdef ALARM_SNOOZE_EN
   localparam int TW = $clog2(SNOOZE_MINS * SECS_PER_MIN + 1);
   localparam logic [TW-1:0] SNOOZE_LD = TW'(SNOOZE_MINS * SECS_PER_MIN);
`else
   localparam int TW = $clog2(RING_SECS + 1);
`endif
   localparam logic [TW-1:0] RING_LD = TW'(RING_SECS);

   bcd_time_t    time_s;
   bcd_time_t    alarm_s;
   alarm_state_e state_q, state_d;
   logic         match_q, match_d;
   logic         ringing_q, ringing_d;
   logic         buzzer_q, buzzer_d;
   logic         armed_led_q, armed_led_d;
   logic         trigger;
   logic         timer_load;
   logic [TW-1:0] timer_val;
   logic         timer_expire;

   assign time_s  = time_bcd;
   assign alarm_s = alarm_bcd;
   assign match_d = (time_s == alarm_s);
   // Edge on match, masked while adjusting, so each matching minute rings at most once.
   assign trigger = match_d && !match_q && !adjusting;

   always_comb begin
      state_d = state_q;
      if (!arm) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ARMED;
            ARMED:   if (trigger) state_d = RINGING;
            RINGING: begin
               if (stop) begin
                  state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
               end else if (snooze) begin
                  state_d = SNOOZING;
`endif
               end else if (timer_expire) begin
                  state_d = ARMED;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZING: begin
               if (stop) begin
                  state_d = ARMED;
               end else if (timer_expire) begin
                  state_d = RINGING;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end

      timer_load = (state_d != state_q);
      timer_val  = '0;
      if (state_d == RINGING) timer_val = RING_LD;
`ifdef ALARM_SNOOZE_EN
      if (state_d == SNOOZING) timer_val = SNOOZE_LD;
`endif

      buzzer_d = 1'b0;
      if (state_d == RINGING) begin
         if (state_q != RINGING) begin
            buzzer_d = 1'b1;
         end else if (tick_1hz) begin
            buzzer_d = !buzzer_q;
         end else begin
            buzzer_d = buzzer_q;
         end
      end

      ringing_d   = (state_d == RINGING);
      armed_led_d = (state_d != IDLE);
   end

   sec_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .tick     (tick_1hz),
      .expire   (timer_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         match_q     <= 1'b1;
         ringing_q   <= 1'b0;
         buzzer_q    <= 1'b0;
         armed_led_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_q     <= match_d;
         ringing_q   <= ringing_d;
         buzzer_q    <= buzzer_d;
         armed_led_q <= armed_led_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   logic snoozed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snoozed_q <= 1'b0;
      end else begin
         snoozed_q <= (state_d == SNOOZING);
      end
   end

   assign snoozed = snoozed_q;
`else
   logic snooze_unused;

   assign snooze_unused = snooze;
   assign snoozed       = 1'b0;
`endif

   assign ringing   = ringing_q;
   assign buzzer    = buzzer_q;
   assign armed_led = armed_led_q;

endmodule
